// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared constants, sprite attribute layout and render-state
//               encoding for the sprite line renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SPR_SIZE = 32;

    // Attribute word layout as written by the CPU
    localparam int ATTR_X_LSB   = 0;
    localparam int ATTR_X_W     = 10;
    localparam int ATTR_Y_LSB   = 10;
    localparam int ATTR_Y_W     = 10;
    localparam int ATTR_IMG_LSB = 20;
    localparam int ATTR_IMG_W   = 3;
    localparam int ATTR_EN_BIT  = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } render_state_e;

    typedef struct packed {
        logic                  en;
        logic [ATTR_IMG_W-1:0] img;
        logic [ATTR_Y_W-1:0]   y;
        logic [ATTR_X_W-1:0]   x;
    } spr_attr_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_renderer_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Two banks of 640 x 12-bit pixels. One render write port, one
//               registered display read port and one display clear port that
//               writes the clear value back over an entry already shown.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import vga_pkg::*;
#(
    parameter logic [11:0] CLEAR_VALUE = 12'hF0F
) (
    input  logic        clk,
    input  logic        wr_en_i,
    input  logic        wr_bank_i,
    input  logic [9:0]  wr_addr_i,
    input  logic [11:0] wr_data_i,
    input  logic        rd_en_i,
    input  logic        rd_bank_i,
    input  logic [9:0]  rd_addr_i,
    output logic [11:0] rd_data_o,
    input  logic        clr_en_i,
    input  logic        clr_bank_i,
    input  logic [9:0]  clr_addr_i
);

    logic [11:0] mem_q [0:1][0:H_ACTIVE-1];
    logic [11:0] rd_data_q;

    // Storage writes; the render port is listed last so it would win a tie,
    // although the two ports always address opposite banks in practice.
    always_ff @(posedge clk) begin
        if (clr_en_i) begin
            mem_q[clr_bank_i][clr_addr_i] <= CLEAR_VALUE;
        end
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Synchronous display read, one cycle of latency
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/sprite_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_renderer
// Description : Renders up to 8 32x32 sprites into a double-buffered line
//               buffer one line ahead of the display and streams the
//               composited 12-bit RGB pixel back to the VGA driver.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_renderer
    import vga_pkg::*;
#(
    parameter int          N_SPR       = 8,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        h_valid,
    input  logic        v_valid,
    input  logic        spr_we,
    input  logic [2:0]  spr_sel,
    input  logic [31:0] spr_wdata,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] vga_data,
    output logic        render_busy
);

    spr_attr_t     shadow_q [N_SPR];
    spr_attr_t     active_q [N_SPR];
    spr_attr_t     w_wr_attr;
    spr_attr_t     w_cur;
    logic          w_unused_attr_bits;

    logic          h_valid_q, v_valid_q;
    logic          w_trigger, w_vblank_start;

    render_state_e state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [9:0]    x_q, x_d;
    logic [2:0]    img_q, img_d;
    logic [9:0]    target_q, target_d;
    logic          buf_sel_q, buf_sel_d;
    logic          wr_pend_q, wr_pend_d;
    logic [10:0]   wr_addr_q, wr_addr_d;

    logic [10:0]   w_diff;
    logic          w_hit;
    logic          w_wr_en;

    logic          w_rd_en, w_rd_bank;
    logic          clr_pend_q, clr_bank_q;
    logic [9:0]    clr_addr_q;
    logic          show_q;
    logic [11:0]   w_entry;

    assign w_wr_attr.x   = spr_wdata[ATTR_X_LSB +: ATTR_X_W];
    assign w_wr_attr.y   = spr_wdata[ATTR_Y_LSB +: ATTR_Y_W];
    assign w_wr_attr.img = spr_wdata[ATTR_IMG_LSB +: ATTR_IMG_W];
    assign w_wr_attr.en  = spr_wdata[ATTR_EN_BIT];
    assign w_unused_attr_bits = ^spr_wdata[30:23];

    assign w_trigger      = h_valid & ~h_valid_q;
    assign w_vblank_start = ~v_valid & v_valid_q;

    // Shadow table takes CPU writes; active table snapshots it at vblank.
    // The snapshot reads the pre-write shadow value on a same-cycle write.
    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < N_SPR; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (spr_we && (32'(spr_sel) < N_SPR)) begin
                shadow_q[spr_sel] <= w_wr_attr;
            end
            if (w_vblank_start) begin
                for (int i = 0; i < N_SPR; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Line-relative vertical test: T-y computed one bit wider so T<y is a miss
    assign w_cur  = active_q[idx_q];
    assign w_diff = {1'b0, target_q} - {1'b0, w_cur.y};
    assign w_hit  = w_cur.en && (target_q < 10'(V_ACTIVE)) &&
                    !w_diff[10] && (w_diff[9:5] == 5'd0);

    // Render FSM state and pipeline registers
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            img_q     <= '0;
            target_q  <= '0;
            buf_sel_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            h_valid_q <= 1'b0;
            v_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            img_q     <= img_d;
            target_q  <= target_d;
            buf_sel_q <= buf_sel_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            h_valid_q <= h_valid;
            v_valid_q <= v_valid;
        end
    end

    // Next-state logic; a line trigger restarts the pass regardless of state
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        col_d     = col_q;
        row_d     = row_q;
        x_d       = x_q;
        img_d     = img_q;
        target_d  = target_q;
        buf_sel_d = buf_sel_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        if (w_trigger) begin
            state_d   = EVAL;
            idx_d     = 3'(N_SPR - 1);
            col_d     = '0;
            buf_sel_d = ~buf_sel_q;
            target_d  = v_valid ? (v_addr + 10'd1) : 10'd0;
        end else begin
            case (state_q)
                EVAL: begin
                    if (w_hit) begin
                        state_d = FETCH;
                        col_d   = '0;
                        row_d   = w_diff[4:0];
                        x_d     = w_cur.x;
                        img_d   = w_cur.img;
                    end else if (idx_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
                FETCH: begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = {1'b0, x_q} + {6'd0, col_q};
                    col_d     = col_q + 5'd1;
                    if (col_q == 5'(SPR_SIZE - 1)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (idx_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EVAL;
                        idx_d   = idx_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr    = (state_q == FETCH) ? {img_q, row_q, col_q} : 13'd0;
    assign render_busy = (state_q != IDLE);

    // A pending pixel is dropped if transparent, off the right edge, or if a
    // trigger/reset has abandoned the pass (the bank is about to be shown).
    assign w_wr_en = wr_pend_q && !w_trigger && !reset &&
                     (rom_data != TRANSPARENT) && (wr_addr_q < 11'(H_ACTIVE));

    // In the trigger cycle the swap has not landed yet, so the bank just
    // rendered is still the one addressed by buf_sel_q.
    assign w_rd_en   = h_valid && (h_addr < 10'(H_ACTIVE));
    assign w_rd_bank = w_trigger ? buf_sel_q : ~buf_sel_q;

    // Display-side pipeline: clear-on-read address and output gating
    always_ff @(posedge pclk) begin
        if (reset) begin
            clr_pend_q <= 1'b0;
            clr_bank_q <= 1'b0;
            clr_addr_q <= '0;
            show_q     <= 1'b0;
        end else begin
            clr_pend_q <= w_rd_en;
            clr_bank_q <= w_rd_bank;
            clr_addr_q <= h_addr;
            show_q     <= h_valid && v_valid;
        end
    end

    line_buffer #(
        .CLEAR_VALUE (TRANSPARENT)
    ) u_line_buffer (
        .clk        (pclk),
        .wr_en_i    (w_wr_en),
        .wr_bank_i  (buf_sel_q),
        .wr_addr_i  (wr_addr_q[9:0]),
        .wr_data_i  (rom_data),
        .rd_en_i    (w_rd_en),
        .rd_bank_i  (w_rd_bank),
        .rd_addr_i  (h_addr),
        .rd_data_o  (w_entry),
        .clr_en_i   (clr_pend_q && !reset),
        .clr_bank_i (clr_bank_q),
        .clr_addr_i (clr_addr_q)
    );

    assign vga_data = !show_q ? 12'd0 :
                      ((w_entry == TRANSPARENT) ? BG_COLOR : w_entry);

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_renderer
// Description : Directed bench for sprite_line_renderer. Drives compressed
//               VGA timing (640 active + 20 blank cycles per line, only the
//               lines of interest), models the sprite ROM, and compares
//               captured scanlines against a table of expected pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_renderer;

    localparam int LINE_LEN = 660;

    logic        pclk;
    logic        reset;
    logic [9:0]  h_addr, v_addr;
    logic        h_valid, v_valid;
    logic        spr_we;
    logic [2:0]  spr_sel;
    logic [31:0] spr_wdata;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] vga_data;
    logic        render_busy;

    sprite_line_renderer dut (
        .pclk        (pclk),
        .reset       (reset),
        .h_addr      (h_addr),
        .v_addr      (v_addr),
        .h_valid     (h_valid),
        .v_valid     (v_valid),
        .spr_we      (spr_we),
        .spr_sel     (spr_sel),
        .spr_wdata   (spr_wdata),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .vga_data    (vga_data),
        .render_busy (render_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Sprite ROM model: solid colour per image; image 4 has a transparent column 5
    logic [11:0] rom [0:8191];
    always @(posedge pclk) rom_data <= rom[rom_addr];

    function automatic logic [11:0] colour(input int img);
        case (img)
            0: colour = 12'h111;
            1: colour = 12'h0F0;
            2: colour = 12'hF00;
            3: colour = 12'h00F;
            4: colour = 12'h0AB;
            5: colour = 12'h555;
            6: colour = 12'h666;
            default: colour = 12'h777;
        endcase
    endfunction

    typedef struct {
        int          ph;
        int          line;
        int          x;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_run = 0;
    int          last_busy = 0;
    logic [11:0] px [0:639];

    // Length of each contiguous render_busy run
    always @(negedge pclk) begin
        if (render_busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    task automatic add(input int ph, input int line, input int x, input logic [11:0] exp);
        vec_t v;
        v.ph = ph; v.line = line; v.x = x; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_spr(input int sel, input int x, input int y, input int img, input bit en);
        @(negedge pclk);
        spr_we    = 1'b1;
        spr_sel   = 3'(sel);
        spr_wdata = {en, 8'hA5, 3'(img), 10'(y), 10'(x)};
        @(negedge pclk);
        spr_we    = 1'b0;
    endtask

    // One scanline; px[k] captures the pixel for h_addr=k. rst_k >= 0 pulses
    // reset at that cycle and checks the outputs right after it.
    task automatic run_line(input int v, input bit vv, input int ph, input int rst_k,
                            input logic [12:0] rst_rom);
        for (int k = 0; k < LINE_LEN; k++) begin
            @(negedge pclk);
            if (k >= 1 && k <= 640) px[k-1] = vga_data;
            if (rst_k >= 0 && k == rst_k) begin
                check("busy_in_fetch", 32'(render_busy), 32'd1);
                check("rom_addr_in_fetch", 32'(rom_addr), 32'(rst_rom));
                reset = 1'b1;
            end else if (rst_k >= 0 && k == rst_k + 1) begin
                check("busy_after_rst", 32'(render_busy), 32'd0);
                check("rom_addr_after_rst", 32'(rom_addr), 32'd0);
                check("vga_data_after_rst", 32'(vga_data), 32'd0);
                reset = 1'b0;
            end
            if (k == 650) begin
                check("busy_idle_eol", 32'(render_busy), 32'd0);
                check("rom_addr_idle_eol", 32'(rom_addr), 32'd0);
            end
            h_valid = (k < 640);
            h_addr  = (k < 640) ? 10'(k) : 10'd0;
            v_addr  = 10'(v);
            v_valid = vv;
        end
        foreach (vecs[j]) begin
            if (vecs[j].ph == ph && vecs[j].line == v)
                check($sformatf("pix ph%0d y%0d x%0d", ph, v, vecs[j].x),
                      32'(px[vecs[j].x]), 32'(vecs[j].exp));
        end
    endtask

    task automatic end_frame();
        run_line(479, 1'b1, -1, -1, 13'd0);
        run_line(480, 1'b0, -1, -1, 13'd0);
    endtask

    task automatic load_worst();
        for (int i = 0; i < 8; i++) set_spr(i, i * 40, 400, i, 1'b1);
    endtask

    initial begin
        // ROM contents
        for (int img = 0; img < 8; img++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++)
                    rom[img * 1024 + r * 32 + c] = (img == 4 && c == 5) ? 12'hF0F : colour(img);

        // Expected-pixel table
        // 1: single sprite x=100 y=50 img1
        add(1, 49, 100, 12'h000);
        add(1, 50,  99, 12'h000); add(1, 50, 100, 12'h0F0);
        add(1, 50, 131, 12'h0F0); add(1, 50, 132, 12'h000);
        add(1, 81, 100, 12'h0F0); add(1, 81, 131, 12'h0F0);
        add(1, 82, 100, 12'h000);
        // 2: sprite0 red x=200 over sprite3 blue x=210, y=10
        add(2, 10, 199, 12'h000); add(2, 10, 200, 12'hF00);
        add(2, 10, 210, 12'hF00); add(2, 10, 231, 12'hF00);
        add(2, 10, 232, 12'h00F); add(2, 10, 241, 12'h00F);
        add(2, 10, 242, 12'h000);
        // 3: right edge + transparent column, x=620 y=200 img4
        add(3, 200, 620, 12'h0AB); add(3, 200, 624, 12'h0AB);
        add(3, 200, 625, 12'h000); add(3, 200, 626, 12'h0AB);
        add(3, 200, 639, 12'h0AB); add(3, 200,   0, 12'h000);
        add(3, 200,  11, 12'h000);
        // 4..6: frame-coherent move of sprite 2 from y=100 to y=300
        add(4, 100, 300, 12'h0F0); add(4, 100, 331, 12'h0F0); add(4, 100, 332, 12'h000);
        add(5, 130, 300, 12'h0F0); add(5, 300, 300, 12'h000);
        add(6, 100, 300, 12'h000); add(6, 300, 300, 12'h0F0); add(6, 300, 331, 12'h0F0);
        // 7 and 9: all eight sprites on line 400
        for (int i = 0; i < 8; i++) begin
            add(7, 400, i * 40 + 10, colour(i));
            add(9, 400, i * 40 + 10, colour(i));
        end
        add(7, 400, 320, 12'h000);
        add(9, 400, 320, 12'h000);

        // Reset
        reset = 1'b1; h_addr = '0; v_addr = '0; h_valid = 1'b0; v_valid = 1'b0;
        spr_we = 1'b0; spr_sel = '0; spr_wdata = '0;
        repeat (3) @(negedge pclk);
        reset = 1'b0;
        @(negedge pclk);
        check("reset_vga_data", 32'(vga_data), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_busy", 32'(render_busy), 32'd0);

        // Single sprite
        set_spr(0, 100, 50, 1, 1'b1);
        end_frame();
        for (int v = 47; v <= 51; v++) begin
            run_line(v, 1'b1, 1, -1, 13'd0);
            if (v == 49) check("busy_one_hit", 32'(last_busy), 32'd41);
        end
        for (int v = 80; v <= 82; v++) run_line(v, 1'b1, 1, -1, 13'd0);

        // Overlap priority
        set_spr(0, 200, 10, 2, 1'b1);
        set_spr(3, 210, 10, 3, 1'b1);
        end_frame();
        for (int v = 9; v <= 11; v++) run_line(v, 1'b1, 2, -1, 13'd0);

        // Transparency and right edge
        set_spr(0, 0, 0, 0, 1'b0);
        set_spr(3, 0, 0, 0, 1'b0);
        set_spr(5, 620, 200, 4, 1'b1);
        end_frame();
        run_line(199, 1'b1, 3, -1, 13'd0);
        run_line(200, 1'b1, 3, -1, 13'd0);

        // Frame-coherent update
        set_spr(5, 0, 0, 0, 1'b0);
        set_spr(2, 300, 100, 1, 1'b1);
        end_frame();
        run_line(99, 1'b1, 4, -1, 13'd0);
        run_line(100, 1'b1, 4, -1, 13'd0);
        set_spr(2, 300, 300, 1, 1'b1);
        run_line(129, 1'b1, 5, -1, 13'd0);
        run_line(130, 1'b1, 5, -1, 13'd0);
        run_line(299, 1'b1, 5, -1, 13'd0);
        run_line(300, 1'b1, 5, -1, 13'd0);
        end_frame();
        run_line(99, 1'b1, 6, -1, 13'd0);
        run_line(100, 1'b1, 6, -1, 13'd0);
        run_line(299, 1'b1, 6, -1, 13'd0);
        run_line(300, 1'b1, 6, -1, 13'd0);

        // Worst-case load
        set_spr(2, 0, 0, 0, 1'b0);
        load_worst();
        end_frame();
        run_line(399, 1'b1, 7, -1, 13'd0);
        check("busy_worst_case", 32'(last_busy), 32'd272);
        run_line(400, 1'b1, 7, -1, 13'd0);

        // Reset mid-FETCH: cycle 10 is column 8 of sprite 7 (img7, row 0)
        run_line(399, 1'b1, 8, 10, {3'd7, 5'd0, 5'd8});
        load_worst();
        end_frame();
        run_line(399, 1'b1, 9, -1, 13'd0);
        run_line(400, 1'b1, 9, -1, 13'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Per-scanline sprite compositor that feeds `vga_data` to `vga_driver`. It consumes the driver's `h_addr`/`v_addr`/`h_valid`/`v_valid` and renders up to 8 sprites of 32×32 pixels into a double-buffered 640-entry line buffer one line ahead of the display. It streams composited 12-bit RGB back to the driver. The CPU updates sprite attributes through a simple write port, and the new values take effect at frame granularity.

## Interface
- `N_SPR`, 8: sprite count; fixed, max 8.
- `TRANSPARENT`, 12'hF0F: colour key; these ROM pixels are not drawn.
- `BG_COLOR`, 12'h000: colour shown where no sprite pixel exists.

Ports:
- `pclk` in 1: 25 MHz pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `h_addr` in 10: current pixel x from `vga_driver`.
- `v_addr` in 10: current pixel y from `vga_driver`.
- `h_valid` in 1: horizontal active from `vga_driver`.
- `v_valid` in 1: vertical active from `vga_driver`.
- `spr_we` in 1: attribute write strobe.
- `spr_sel` in 3: sprite index to write.
- `spr_wdata` in 32: attribute word. Fields: [9:0] x, [19:10] y, [22:20] img, [31] en; other bits ignored.
- `rom_addr` out 13: sprite ROM address `{img, row[4:0], col[4:0]}`.
- `rom_data` in 12: ROM pixel; valid 1 cycle after `rom_addr`.
- `vga_data` out 12: composited pixel to `vga_driver`.
- `render_busy` out 1: render FSM not in IDLE.

## Operation
- **Attribute tables.**
  - Shadow table: written by `spr_we` at `spr_sel`.
  - Active table: copied from shadow on the `v_valid` 1→0 edge (start of vblank).
  - If a write and the copy occur in the same cycle, the copy takes the pre-write value.
- **Trigger.** Each `h_valid` 0→1 edge does three things:
  - Swaps the front/back buffers.
  - Latches target line T = `v_valid` ? `v_addr`+1 : 0.
  - Starts a render pass into the back buffer.
- **Render FSM.**
  - IDLE → EVAL(i=N_SPR-1) on trigger.
  - EVAL (1 cycle): hit if en ∧ T<480 ∧ 0 ≤ T−y ≤ 31 (10-bit unsigned compare, no wrap). Hit → FETCH with col=0. Miss → next i, or IDLE after i=0.
  - FETCH (32 cycles): issues `rom_addr` = `{img, T−y, col}` for col 0..31. Each returned pixel is written one cycle later to buffer address x+col, unless the pixel equals TRANSPARENT or x+col ≥ 640 (11-bit sum; dropped, no wrap).
  - DRAIN (1 cycle): completes the last write, then goes to the next i or IDLE.
- **Priority.** Sprites render from index 7 down to 0, so lower indices overwrite higher ones. Sprite 0 is on top.
- **Display side.**
  - While `h_valid`=1, the front buffer is read at `h_addr`.
  - Whenever `h_valid`=1, the same entry is written to TRANSPARENT on the following cycle (clear-on-read). This includes vblank lines.
- **Output.** `vga_data` = registered(entry==TRANSPARENT ? BG_COLOR : entry) when `h_valid`∧`v_valid` held in the previous cycle; otherwise 0.
- **Re-trigger while busy.** The current pass is abandoned and restarts cleanly in EVAL(7).

## Timing
- Render cost: 1 cycle per miss, 34 cycles per hit; worst case 272 cycles, which fits within the 800-cycle line.
- Display latency: 1 pclk from `h_addr` to `vga_data`. This produces a fixed, documented 1-pixel right shift.
- `rom_addr` changes only in FETCH; otherwise it holds 0.
- Reset values: `vga_data`=0, `rom_addr`=0, `render_busy`=0, FSM=IDLE, buffer select=0, both tables all-zero (all sprites disabled).
- Line buffer RAM contents are not reset. Clear-on-read scrubs them within one frame.
- Reset mid-pass: the FSM returns to IDLE immediately; no further buffer writes occur.
- Line 0 rendering: vblank lines repeatedly render T=0. The last vblank line's pass produces line 0.

## Structure
- Shared package `vga_pkg`:
  - Constants H_ACTIVE=640, V_ACTIVE=480, SPR_SIZE=32.
  - Attribute field offsets and widths.
  - Render state enum {IDLE, EVAL, FETCH, DRAIN}.
- Sub-module `line_buffer`: 2×640×12 RAM with one render write port, one display read port, and one display clear-write port. The bank select is input as the buffer-select bit.

## Test plan
- **Single sprite.** Sprite 0 at x=100, y=50, img=1, en=1; ROM img1 is solid 12'h0F0.
  - Line 50–81, pixels 100–131: 12'h0F0 (1-cycle delayed).
  - Line 49 and line 82: BG_COLOR.
- **Overlap priority.** Sprite 0 (red) at x=200 and sprite 3 (blue) at x=210, both y=10.
  - Columns 210–231 show red; columns 232–241 show blue.
- **Transparency and right edge.** Sprite at x=620 whose ROM column 5 = TRANSPARENT.
  - Pixel 625 = BG_COLOR.
  - Pixels 620–639 are otherwise drawn; nothing wraps to x 0–11.
- **Frame-coherent update.** Write sprite 2 y=100→300 mid-frame.
  - The current frame still shows y=100.
  - After the vblank copy, the sprite appears at y=300.
- **Worst-case load.** All 8 sprites enabled on the same line.
  - `render_busy` is high for exactly 272 cycles after the `h_valid` rise.
  - The line displays correctly.
- **Reset mid-FETCH.** Assert `reset` for 1 cycle during FETCH.
  - `render_busy`, `rom_addr`, and `vga_data` are all 0 the next cycle.
  - Output is correct again from the next frame.
